rgb_pwm_driver: RTL and testbench

- Downstream output stage for the colour-wheel intensity generator.
- Accepts one {R,G,B} duty triple per valid/ready handshake and buffers it, then swaps it into the active set only at a PWM period boundary, so a colour never changes mid-period.
- Drives the three active-low RGB pins with glitch-free, registered PWM.
- Decouples intensity producers from the pin timing.

---
 rtl/rgb_pkg.sv | 9 +
 rtl/rgb_pwm_driver_timebase.sv | 24 ++
 rtl/rgb_pwm_driver.sv | 56 +++++
 tb/tb_rgb_pwm_driver.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// rgb_pkg: shared duty-triple type for the colour-wheel generator and PWM driver
package rgb_pkg;
  localparam int PWM_BITS = 8;
  typedef struct packed {
    logic [PWM_BITS-1:0] r;
    logic [PWM_BITS-1:0] g;
    logic [PWM_BITS-1:0] b;
  } rgb_duty_t;
endpackage

// File: rtl/rgb_pwm_driver_timebase.sv
// pwm_timebase: prescaled PWM slot counter with tick and period-wrap strobes
module pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 46
) (
  input  logic                CLK,
  input  logic                RST,
  output logic                tick,
  output logic                wrap,
  output logic [PWM_BITS-1:0] pwm_cnt
);
  localparam int PW = PRESCALE > 0 ? $clog2(PRESCALE + 1) : 1;
  logic [PW-1:0] prescaler;
  assign tick = prescaler == PW'(PRESCALE);
  assign wrap = tick && &pwm_cnt;
  always_ff @(posedge CLK)
    if (RST) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: buffers one duty triple per handshake and drives active-low
// RGB pins with registered PWM, swapping duties only at period boundaries
module rgb_pwm_driver #(
  parameter int PWM_BITS = rgb_pkg::PWM_BITS,
  parameter int PRESCALE = 46
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PWM_BITS-1:0] r_duty,
  input  logic [PWM_BITS-1:0] g_duty,
  input  logic [PWM_BITS-1:0] b_duty,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B,
  output logic                period_start
);
  import rgb_pkg::*;
  typedef struct packed {
    logic [PWM_BITS-1:0] r;
    logic [PWM_BITS-1:0] g;
    logic [PWM_BITS-1:0] b;
  } duty_t;
  logic                tick, wrap, pending_valid;
  logic [PWM_BITS-1:0] pwm_cnt;
  duty_t               pending, active;
  pwm_timebase #(.PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE)) u_tb (
    .CLK(CLK), .RST(RST), .tick(tick), .wrap(wrap), .pwm_cnt(pwm_cnt)
  );
  assign in_ready = !pending_valid && !RST;
  // swap and transfer are exclusive: a transfer needs pending empty, a swap needs it full
  always_ff @(posedge CLK)
    if (RST) begin
      pending_valid <= 1'b0;
      pending       <= '0;
      active        <= '0;
      RGB_R         <= 1'b1;
      RGB_G         <= 1'b1;
      RGB_B         <= 1'b1;
      period_start  <= 1'b0;
    end else begin
      if (wrap && pending_valid) begin
        active        <= pending;
        pending_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
        pending       <= '{r: r_duty, g: g_duty, b: b_duty};
        pending_valid <= 1'b1;
      end
      RGB_R        <= !(enable && pwm_cnt < active.r);
      RGB_G        <= !(enable && pwm_cnt < active.g);
      RGB_B        <= !(enable && pwm_cnt < active.b);
      period_start <= wrap;
    end
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: directed vectors plus multi-cycle sequences, 48-clock period
module tb_rgb_pwm_driver;
  logic       CLK = 1'b0, RST = 1'b1, enable = 1'b1, in_valid = 1'b0;
  logic [3:0] r_duty = '0, g_duty = '0, b_duty = '0;
  logic       in_ready, RGB_R, RGB_G, RGB_B, period_start;
  int         checks = 0, failures = 0;

  rgb_pwm_driver #(.PWM_BITS(4), .PRESCALE(2)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .r_duty(r_duty), .g_duty(g_duty), .b_duty(b_duty),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B), .period_start(period_start)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] r, g, b;
    int         er, eg, eb;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic count_to_ps(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!period_start && n < 200);
  endtask

  task automatic wait_ps();
    int n;
    count_to_ps(n);
    check("period_start_timeout", period_start, 1);
  endtask

  task automatic measure(output int lr, output int lg, output int lb, output int ready0);
    lr = 0; lg = 0; lb = 0; ready0 = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        in_valid = 1'b0;
        ready0 = int'(in_ready);
      end
      lr += int'(!RGB_R);
      lg += int'(!RGB_G);
      lb += int'(!RGB_B);
    end
  endtask

  task automatic present(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    r_duty = r; g_duty = g; b_duty = b;
    in_valid = 1'b1;
  endtask

  initial begin
    int n, lr, lg, lb, rdy, hold_ok, off_ok;
    vecs[0] = '{r: 4'd4,  g: 4'd0,  b: 4'd15, er: 12, eg: 0,  eb: 45};
    vecs[1] = '{r: 4'd8,  g: 4'd2,  b: 4'd0,  er: 24, eg: 6,  eb: 0};
    vecs[2] = '{r: 4'd15, g: 4'd15, b: 4'd15, er: 45, eg: 45, eb: 45};
    vecs[3] = '{r: 4'd1,  g: 4'd0,  b: 4'd7,  er: 3,  eg: 0,  eb: 21};

    repeat (3) @(negedge CLK);
    check("reset_pins", int'({RGB_R, RGB_G, RGB_B}), 7);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_period_start", int'(period_start), 0);
    RST = 1'b0;
    #1 check("idle_in_ready", int'(in_ready), 1);
    count_to_ps(n);
    check("first_period_start", n, 48);
    count_to_ps(n);
    check("second_period_start", n, 48);
    check("idle_pins", int'({RGB_R, RGB_G, RGB_B}), 7);

    foreach (vecs[k]) begin
      check("vec_ready_before", int'(in_ready), 1);
      present(vecs[k].r, vecs[k].g, vecs[k].b);
      @(negedge CLK);
      in_valid = 1'b0;
      check("vec_ready_after_xfer", int'(in_ready), 0);
      wait_ps();
      measure(lr, lg, lb, rdy);
      check("vec_r_low", lr, vecs[k].er);
      check("vec_g_low", lg, vecs[k].eg);
      check("vec_b_low", lb, vecs[k].eb);
    end

    present(4'd4, 4'd4, 4'd4);
    @(negedge CLK);
    check("bp_ready_after_first", int'(in_ready), 0);
    present(4'd8, 4'd8, 4'd8);
    hold_ok = 1; n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (!period_start && in_ready) hold_ok = 0;
    end while (!period_start && n < 200);
    check("bp_ready_held_low", hold_ok, 1);
    check("bp_ready_after_swap", int'(in_ready), 1);
    measure(lr, lg, lb, rdy);
    check("bp_second_accepted", rdy, 0);
    check("bp_period1_r_low", lr, 12);
    measure(lr, lg, lb, rdy);
    check("bp_period2_r_low", lr, 24);

    repeat (47) @(negedge CLK);
    present(4'd12, 4'd12, 4'd12);
    @(negedge CLK);
    check("wrap_xfer_period_start", int'(period_start), 1);
    check("wrap_xfer_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    measure(lr, lg, lb, rdy);
    check("wrap_old_duty_r_low", lr, 24);
    measure(lr, lg, lb, rdy);
    check("wrap_new_duty_r_low", lr, 36);

    off_ok = 1;
    for (int i = 1; i <= 48; i++) begin
      @(negedge CLK);
      if (i == 10) begin
        check("en_lit_before_drop", int'(RGB_R), 0);
        enable = 1'b0;
      end
      if (i >= 11 && i <= 30 && {RGB_R, RGB_G, RGB_B} != 3'b111) off_ok = 0;
      if (i == 30) enable = 1'b1;
    end
    check("en_pins_forced_off", off_ok, 1);
    check("en_cadence_kept", int'(period_start), 1);
    measure(lr, lg, lb, rdy);
    check("en_resumed_r_low", lr, 36);
    check("en_resumed_b_low", lb, 36);

    present(4'd2, 4'd2, 4'd2);
    @(negedge CLK);
    in_valid = 1'b0;
    check("rst_pending_full", int'(in_ready), 0);
    repeat (3) @(negedge CLK);
    check("rst_lit_before", int'(RGB_R), 0);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_pins", int'({RGB_R, RGB_G, RGB_B}), 7);
    check("rst_mid_ready", int'(in_ready), 0);
    @(negedge CLK);
    RST = 1'b0;
    #1 check("rst_pending_lost", int'(in_ready), 1);
    count_to_ps(n);
    check("rst_first_period_start", n, 48);
    measure(lr, lg, lb, rdy);
    check("rst_duty_cleared", lr + lg + lb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
